// File: rtl/mem_copy_if.sv
// Control and data-memory bus bundle for the memory copy/fill engine.
// master = engine side, slave = integrator/testbench side.
interface mem_copy_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] length;
    logic             fill_en;
    logic [31:0]      fill_value;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;
    logic             mem_read;
    logic             mem_write;

    modport master (
        input  start, src_addr, dst_addr, length, fill_en, fill_value, mem_read_data,
        output busy, done, words_done, mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        output start, src_addr, dst_addr, length, fill_en, fill_value, mem_read_data,
        input  busy, done, words_done, mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Autonomous block copy (memmove-safe) / block fill initiator for the data memory port.
// One word moves per RD+WR pair in copy mode, one word per WR cycle in fill mode.
module mem_copy_engine #(
    parameter int LEN_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    mem_copy_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      fill_value_q, fill_value_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;
    logic             fill_en_q, fill_en_d;
    logic             desc_q, desc_d;

    logic [31:0]      offset;
    logic             last_word;
    logic             start_desc;

    assign offset    = 32'(idx_q);
    assign last_word = (words_done_q == len_q - LEN_W'(1));

    // Walk backwards only when the destination starts inside the source block.
    assign start_desc = !bus.fill_en
                     && (bus.dst_addr > bus.src_addr)
                     && ({1'b0, bus.dst_addr} < ({1'b0, bus.src_addr} + 33'(bus.length)));

    // NOTE: datapath registers are reset too so every output and operand is defined after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            fill_value_q <= '0;
            data_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            words_done_q <= '0;
            fill_en_q    <= 1'b0;
            desc_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            fill_value_q <= fill_value_d;
            data_q       <= data_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
            fill_en_q    <= fill_en_d;
            desc_q       <= desc_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no path through the case infers a latch.
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        fill_value_d = fill_value_q;
        data_d       = data_q;
        len_d        = len_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;
        fill_en_d    = fill_en_q;
        desc_d       = desc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d        = bus.src_addr;
                    dst_d        = bus.dst_addr;
                    len_d        = bus.length;
                    fill_en_d    = bus.fill_en;
                    fill_value_d = bus.fill_value;
                    desc_d       = start_desc;
                    idx_d        = start_desc ? (bus.length - LEN_W'(1)) : '0;
                    words_done_d = '0;
                    if (bus.length == '0)  state_d = DONE;
                    else if (bus.fill_en)  state_d = WR;
                    else                   state_d = RD;
                end
            end
            RD: begin
                data_d  = bus.mem_read_data;
                state_d = WR;
            end
            WR: begin
                words_done_d = words_done_q + LEN_W'(1);
                idx_d        = desc_q ? (idx_q - LEN_W'(1)) : (idx_q + LEN_W'(1));
                if (last_word)      state_d = DONE;
                else if (fill_en_q) state_d = WR;
                else                state_d = RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are gated by rst so nothing is issued during the reset cycle itself.
    always_comb begin
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        if (!rst) begin
            case (state_q)
                RD: begin
                    bus.busy        = 1'b1;
                    bus.mem_read    = 1'b1;
                    bus.mem_address = src_q + offset;
                end
                WR: begin
                    bus.busy           = 1'b1;
                    bus.mem_write      = 1'b1;
                    bus.mem_address    = dst_q + offset;
                    bus.mem_write_data = fill_en_q ? fill_value_q : data_q;
                end
                DONE: bus.done = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.words_done = words_done_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a 64K-word memory model, a vector table of
// transfers checked against a memmove/fill reference, and hand-written reset/overlap cases.
module tb_mem_copy_engine;
    localparam int LEN_W = 16;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        fill_en;
        logic [31:0] fill_value;
        int          ignore_at;
        int          exp_lat;
        int          exp_words;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_copy_if #(.LEN_W(LEN_W)) bus ();

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [65536];
    logic [31:0] snap    [65536];
    logic [31:0] exp_mem [65536];

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_write) mem[bus.mem_address[15:0]] <= bus.mem_write_data;
    end

    assign bus.mem_read_data = mem[bus.mem_address[15:0]];

    int          checks = 0;
    int          errors = 0;
    logic        any_access;
    logic        first_wr_seen;
    logic [31:0] first_wr_addr;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next negedge and run the per-cycle protocol checks.
    task automatic tick();
        @(negedge clk);
        check("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        check("busy_in_rd_wr", {31'd0, bus.busy}, {31'd0, bus.mem_read | bus.mem_write});
        if (bus.mem_read || bus.mem_write) any_access = 1'b1;
        if (bus.mem_write && !first_wr_seen) begin
            first_wr_seen = 1'b1;
            first_wr_addr = bus.mem_address;
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic take_snapshot();
        for (int i = 0; i < 65536; i++) begin
            snap[i]    = mem[i];
            exp_mem[i] = mem[i];
        end
    endtask

    task automatic compare_memory(input string name);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== exp_mem[i]) nbad++;
        check({name, " mem_mismatches"}, nbad, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int          lat;
        logic [31:0] a;
        logic [31:0] s;
        take_snapshot();
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.dst + 32'(i);
            s = v.src + 32'(i);
            exp_mem[a[15:0]] = v.fill_en ? v.fill_value : snap[s[15:0]];
        end
        any_access    = 1'b0;
        first_wr_seen = 1'b0;
        first_wr_addr = '0;

        bus.src_addr   = v.src;
        bus.dst_addr   = v.dst;
        bus.length     = v.len;
        bus.fill_en    = v.fill_en;
        bus.fill_value = v.fill_value;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (lat == v.ignore_at) begin
                bus.src_addr   = 32'h500;
                bus.dst_addr   = 32'h600;
                bus.length     = 16'd5;
                bus.fill_en    = 1'b1;
                bus.fill_value = 32'hDEAD_BEEF;
                bus.start      = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            lat++;
        end
        check({name, " done_latency"}, lat, v.exp_lat);
        check({name, " words_done_at_done"}, 32'(bus.words_done), v.exp_words);
        check({name, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        tick();
        check({name, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
        check({name, " words_done_held"}, 32'(bus.words_done), v.exp_words);
        check({name, " idle_address"}, bus.mem_address, 32'd0);
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.dst + 32'(i);
            check($sformatf("%s word %0d", name, i), mem[a[15:0]], exp_mem[a[15:0]]);
        end
        compare_memory(name);
    endtask

    initial begin
        int   lat;
        int   wr_cnt;
        logic hit;
        logic seen_done;

        rst            = 1'b1;
        pre_we         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        any_access     = 1'b0;
        first_wr_seen  = 1'b0;
        first_wr_addr  = '0;
        bus.start      = 1'b0;
        bus.src_addr   = '0;
        bus.dst_addr   = '0;
        bus.length     = '0;
        bus.fill_en    = 1'b0;
        bus.fill_value = '0;

        // src, dst, len, fill_en, fill_value, ignore_at, exp_lat, exp_words
        vecs[0] = '{32'd2,         32'd20,        16'd4, 1'b0, 32'h0,         0, 9, 4};
        vecs[1] = '{32'd10,        32'd12,        16'd4, 1'b0, 32'h0,         0, 9, 4};
        vecs[2] = '{32'd0,         32'h0000_FFFE, 16'd4, 1'b1, 32'hFFFF_0000, 0, 5, 4};
        vecs[3] = '{32'd7,         32'd70,        16'd0, 1'b0, 32'h0,         0, 1, 0};
        vecs[4] = '{32'd40,        32'd60,        16'd3, 1'b0, 32'h0,         2, 7, 3};
        vecs[5] = '{32'd31,        32'd30,        16'd3, 1'b0, 32'h0,         0, 7, 3};
        vecs[6] = '{32'd0,         32'hFFFF_FFFF, 16'd2, 1'b1, 32'h1234_5678, 0, 3, 2};

        tick();
        tick();
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst mem_write", {31'd0, bus.mem_write}, 32'd0);
        rst = 1'b0;
        tick();
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset words_done", 32'(bus.words_done), 32'd0);
        check("reset mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("reset mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("reset mem_address", bus.mem_address, 32'd0);
        check("reset mem_write_data", bus.mem_write_data, 32'd0);

        for (int i = 0; i < 4; i++) preload(16'(2 + i), 32'(1 + i));
        for (int i = 0; i < 4; i++) preload(16'(10 + i), 32'(10 + i));
        for (int i = 0; i < 3; i++) preload(16'(40 + i), 32'h40 + 32'(i));
        for (int i = 0; i < 3; i++) preload(16'(31 + i), 32'h31 + 32'(i));
        for (int i = 0; i < 8; i++) preload(16'(100 + i), 32'h100 + 32'(i));

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            case (i)
                0: begin
                    check("copy dst[20]", mem[20], 32'd1);
                    check("copy dst[23]", mem[23], 32'd4);
                    check("copy src[2] kept", mem[2], 32'd1);
                    check("copy src[5] kept", mem[5], 32'd4);
                end
                1: begin
                    check("overlap first_write_addr", first_wr_addr, 32'd15);
                    check("overlap mem[12]", mem[12], 32'hA);
                    check("overlap mem[13]", mem[13], 32'hB);
                    check("overlap mem[14]", mem[14], 32'hC);
                    check("overlap mem[15]", mem[15], 32'hD);
                    check("overlap mem[10]", mem[10], 32'hA);
                    check("overlap mem[11]", mem[11], 32'hB);
                end
                2: begin
                    check("fill mem[FFFE]", mem[16'hFFFE], 32'hFFFF_0000);
                    check("fill mem[FFFF]", mem[16'hFFFF], 32'hFFFF_0000);
                    check("fill mem[0000]", mem[0], 32'hFFFF_0000);
                    check("fill mem[0001]", mem[1], 32'hFFFF_0000);
                end
                3: check("len0 no_access", {31'd0, any_access}, 32'd0);
                5: check("backward_overlap mem[32]", mem[32], 32'h33);
                default: ;
            endcase
        end

        // Reset on the third WR cycle of an 8-word copy: only two words may land.
        take_snapshot();
        exp_mem[200] = 32'h100;
        exp_mem[201] = 32'h101;
        bus.src_addr = 32'd100;
        bus.dst_addr = 32'd200;
        bus.length   = 16'd8;
        bus.fill_en  = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wr_cnt    = 0;
        hit       = 1'b0;
        lat       = 1;
        while (!hit && lat < 100) begin
            if (bus.mem_write) begin
                wr_cnt++;
                if (wr_cnt == 3) hit = 1'b1;
            end
            if (!hit) begin
                tick();
                lat++;
            end
        end
        check("rst_mid reached_3rd_wr", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid mem_write_in_rst_cycle", {31'd0, bus.mem_write}, 32'd0);
        check("rst_mid mem_read_in_rst_cycle", {31'd0, bus.mem_read}, 32'd0);
        check("rst_mid busy_in_rst_cycle", {31'd0, bus.busy}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid words_done", 32'(bus.words_done), 32'd0);
        check("rst_mid mem_address", bus.mem_address, 32'd0);
        check("rst_mid mem_write_data", bus.mem_write_data, 32'd0);
        check("rst_mid busy", {31'd0, bus.busy}, 32'd0);
        seen_done = 1'b0;
        repeat (20) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        check("rst_mid no_done", {31'd0, seen_done}, 32'd0);
        check("rst_mid mem[200]", mem[200], 32'h100);
        check("rst_mid mem[201]", mem[201], 32'h101);
        check("rst_mid mem[202]", mem[202], snap[202]);
        compare_memory("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
